key_input_conditioner: RTL

Conditions the two raw push-button inputs (mode, add) of the clock/display top level before they reach the mode-status FSM and the time-set logic. Each key is synchronised, debounced and converted into single-cycle press and release pulses; the add key also produces auto-repeat press pulses while held. Outputs drive `key_mode_down`, `key_add_down` and `key_add_negedge` in the top level directly.

---
 rtl/clock_pkg.sv | 15 +
 rtl/key_filter.sv | 127 ++++++++++++
 rtl/key_input_conditioner.sv | 55 +++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared clock/display definitions: key FSM encoding
// and the default timebase constants.
package clock_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    REPEAT   = 2'd2
  } key_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 16384;
  localparam int REPEAT_DELAY_DEF    = 32768;
  localparam int REPEAT_PERIOD_DEF   = 8192;

endpackage

// File: rtl/key_filter.sv
// One push-button: two-flop sync, debounce counter and
// press/hold/repeat FSM producing registered pulses.
module key_filter
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_down,
  output logic key_negedge,
  output logic key_repeating
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);

  logic [1:0]    sync_q;
  logic          sync;
  logic [DW-1:0] db_cnt, db_cnt_n;
  logic          level_n;
  logic          accept, acc_press, acc_rel;
  key_state_e    state, state_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          down_n, neg_n, rep_n;

  assign sync = sync_q[1];

  always_comb begin
    accept   = 1'b0;
    db_cnt_n = '0;
    level_n  = key_level;
    if (sync != key_level) begin
      if (db_cnt == DB_LAST) begin
        accept  = 1'b1;
        level_n = ~key_level;
      end else begin
        db_cnt_n = db_cnt + 1'b1;
      end
    end
  end

  assign acc_press = accept & ~key_level;
  assign acc_rel   = accept & key_level;

  // Release is checked first so it beats a same-cycle repeat expiry
  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    down_n  = 1'b0;
    neg_n   = 1'b0;
    unique case (state)
      RELEASED: begin
        if (acc_press) begin
          state_n = HELD;
          down_n  = 1'b1;
          rcnt_n  = '0;
        end
      end
      HELD: begin
        if (acc_rel) begin
          state_n = RELEASED;
          neg_n   = 1'b1;
          rcnt_n  = '0;
        end else if (REPEAT_EN) begin
          if (rcnt == R_DELAY) begin
            state_n = REPEAT;
            down_n  = 1'b1;
            rcnt_n  = '0;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (acc_rel) begin
          state_n = RELEASED;
          neg_n   = 1'b1;
          rcnt_n  = '0;
        end else if (rcnt == R_PERIOD) begin
          down_n = 1'b1;
          rcnt_n = '0;
        end else begin
          rcnt_n = rcnt + 1'b1;
        end
      end
      default: begin
        state_n = RELEASED;
        rcnt_n  = '0;
      end
    endcase
    rep_n = (state_n == REPEAT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q        <= '0;
      db_cnt        <= '0;
      key_level     <= 1'b0;
      state         <= RELEASED;
      rcnt          <= '0;
      key_down      <= 1'b0;
      key_negedge   <= 1'b0;
      key_repeating <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], key_raw};
      db_cnt        <= db_cnt_n;
      key_level     <= level_n;
      state         <= state_n;
      rcnt          <= rcnt_n;
      key_down      <= down_n;
      key_negedge   <= neg_n;
      key_repeating <= rep_n;
    end
  end

endmodule

// File: rtl/key_input_conditioner.sv
// Conditions the mode and add buttons; add key
// gets auto-repeat, mode key does not.
module key_input_conditioner
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic key_mode_raw,
  input  logic key_add_raw,
  output logic key_mode_level,
  output logic key_add_level,
  output logic key_mode_down,
  output logic key_add_down,
  output logic key_add_negedge,
  output logic key_add_repeating
);

  logic mode_negedge_unused;
  logic mode_repeating_unused;

  key_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b0)
  ) u_mode (
    .clock         (clock),
    .reset         (reset),
    .key_raw       (key_mode_raw),
    .key_level     (key_mode_level),
    .key_down      (key_mode_down),
    .key_negedge   (mode_negedge_unused),
    .key_repeating (mode_repeating_unused)
  );

  key_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b1)
  ) u_add (
    .clock         (clock),
    .reset         (reset),
    .key_raw       (key_add_raw),
    .key_level     (key_add_level),
    .key_down      (key_add_down),
    .key_negedge   (key_add_negedge),
    .key_repeating (key_add_repeating)
  );

endmodule
